// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding,
// the register-zero constant and the performance counter width.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of ID.
// Writes to register zero never create a dependency.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_use_rs,
  input  logic       i_use_rt,
  output logic       o_lu
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_use_rs && (i_id_rs == i_ex_rd);
  assign w_rt_hit = i_use_rt && (i_id_rt == i_ex_rd);
  assign o_lu     = i_ex_memread && (i_ex_rd != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use stalls, jump/branch flushes,
// halt/drain/resume, plus cycle, stall and flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             in_CLK,
  input  logic             in_CLR,
  input  logic [4:0]       in_id_rs,
  input  logic [4:0]       in_id_rt,
  input  logic             in_id_use_rs,
  input  logic             in_id_use_rt,
  input  logic             in_ex_memread,
  input  logic [4:0]       in_ex_rd,
  input  logic             in_id_jump,
  input  logic             in_ex_branch_taken,
  input  logic             in_ex_halt,
  input  logic             in_resume,
  output logic             out_pc_en,
  output logic             out_ifid_en,
  output logic             out_ifid_clr,
  output logic             out_idex_en,
  output logic             out_idex_clr,
  output logic             out_exmem_en,
  output logic             out_memwb_en,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cycles,
  output logic [CNT_W-1:0] out_stalls,
  output logic [CNT_W-1:0] out_flushes
);

  localparam logic [2:0] BUBBLE_RELOAD = 3'(LOAD_BUBBLES - 1);
  localparam logic [1:0] DRAIN_RELOAD  = 2'(DRAIN_CYCLES);

  state_t           r_state, w_state_next;
  logic [2:0]       r_bubble, w_bubble_next;
  logic [1:0]       r_drain, w_drain_next;
  logic [CNT_W-1:0] r_cycles, r_stalls, r_flushes;
  logic             w_lu;
  logic             w_inc_stall;
  logic             w_inc_flush;

  load_use_detect u_lu (
    .i_ex_memread (in_ex_memread),
    .i_ex_rd      (in_ex_rd),
    .i_id_rs      (in_id_rs),
    .i_id_rt      (in_id_rt),
    .i_use_rs     (in_id_use_rs),
    .i_use_rt     (in_id_use_rt),
    .o_lu         (w_lu)
  );

  always_comb begin
    out_pc_en     = 1'b1;
    out_ifid_en   = 1'b1;
    out_ifid_clr  = 1'b0;
    out_idex_en   = 1'b1;
    out_idex_clr  = 1'b0;
    out_exmem_en  = 1'b1;
    out_memwb_en  = 1'b1;
    out_halted    = 1'b0;
    w_state_next  = r_state;
    w_bubble_next = r_bubble;
    w_drain_next  = r_drain;
    w_inc_stall   = 1'b0;
    w_inc_flush   = 1'b0;
    // Outputs are forced to the idle pattern while reset is held.
    if (!in_CLR) begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          if (in_ex_halt) begin
            out_pc_en     = 1'b0;
            out_ifid_en   = 1'b0;
            out_idex_clr  = 1'b1;
            w_state_next  = ST_DRAIN;
            w_drain_next  = DRAIN_RELOAD;
            w_bubble_next = 3'd0;
          end else if (in_ex_branch_taken) begin
            out_ifid_clr  = 1'b1;
            out_idex_clr  = 1'b1;
            w_inc_flush   = 1'b1;
            w_state_next  = ST_RUN;
            w_bubble_next = 3'd0;
          end else if (r_state == ST_STALL) begin
            out_pc_en     = 1'b0;
            out_ifid_en   = 1'b0;
            out_idex_clr  = 1'b1;
            w_inc_stall   = 1'b1;
            w_bubble_next = r_bubble - 3'd1;
            if (r_bubble == 3'd1) w_state_next = ST_RUN;
          end else if (w_lu) begin
            // A concurrent jump is dropped; ID re-presents it after the stall.
            out_pc_en    = 1'b0;
            out_ifid_en  = 1'b0;
            out_idex_clr = 1'b1;
            w_inc_stall  = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              w_state_next  = ST_STALL;
              w_bubble_next = BUBBLE_RELOAD;
            end
          end else if (in_id_jump) begin
            out_ifid_clr = 1'b1;
            w_inc_flush  = 1'b1;
          end
        end
        ST_DRAIN: begin
          out_pc_en    = 1'b0;
          out_ifid_en  = 1'b0;
          out_idex_en  = 1'b0;
          w_drain_next = r_drain - 2'd1;
          if (r_drain == 2'd1) w_state_next = ST_HALT;
        end
        ST_HALT: begin
          out_pc_en    = 1'b0;
          out_ifid_en  = 1'b0;
          out_idex_en  = 1'b0;
          out_exmem_en = 1'b0;
          out_memwb_en = 1'b0;
          out_halted   = 1'b1;
          if (in_resume) w_state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge in_CLK or posedge in_CLR) begin
    if (in_CLR) begin
      r_state   <= ST_RUN;
      r_bubble  <= 3'd0;
      r_drain   <= 2'd0;
      r_cycles  <= '0;
      r_stalls  <= '0;
      r_flushes <= '0;
    end else begin
      r_state  <= w_state_next;
      r_bubble <= w_bubble_next;
      r_drain  <= w_drain_next;
      if (r_state != ST_HALT) r_cycles <= r_cycles + 1'b1;
      if (w_inc_stall) r_stalls <= r_stalls + 1'b1;
      if (w_inc_flush) r_flushes <= r_flushes + 1'b1;
    end
  end

  assign out_cycles  = r_cycles;
  assign out_stalls  = r_stalls;
  assign out_flushes = r_flushes;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage CPU. It drives the enable and clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use stalls, ID-stage jump flushes, EX-stage taken-branch flushes, and halt/drain/resume. It also exposes cycle, stall and flush performance counters to the display logic.

Parameters:
LOAD_BUBBLES, 1, number of ID/EX bubbles inserted per load-use hazard (1..7)
DRAIN_CYCLES, 2, cycles after halt detection during which EX/MEM and MEM/WB keep advancing before freeze (1..3)

Ports:
in_CLK  input  1  clock
in_CLR  input  1  asynchronous active-high reset
in_id_rs  input  5  rs field of instruction in ID
in_id_rt  input  5  rt field of instruction in ID
in_id_use_rs  input  1  ID instruction reads rs
in_id_use_rt  input  1  ID instruction reads rt
in_ex_memread  input  1  EX instruction is a load
in_ex_rd  input  5  destination register of EX instruction
in_id_jump  input  1  unconditional jump resolved in ID
in_ex_branch_taken  input  1  conditional branch taken, resolved in EX
in_ex_halt  input  1  halt syscall currently in EX
in_resume  input  1  resume request (go button), level
out_pc_en  output  1  PC load enable
out_ifid_en  output  1  IF/ID enable
out_ifid_clr  output  1  IF/ID clear
out_idex_en  output  1  ID/EX enable
out_idex_clr  output  1  ID/EX clear (bubble)
out_exmem_en  output  1  EX/MEM enable
out_memwb_en  output  1  MEM/WB enable
out_halted  output  1  high in HALT state
out_cycles  output  32  non-halted cycle count
out_stalls  output  32  load-use stall cycle count
out_flushes  output  32  flush event count

Behaviour:
- Reset: in_CLR is asynchronous and active-high; the clock is in_CLK. On reset: state=RUN, bubble counter=0, drain counter=0, all three perf counters=0.
- Output values during reset and while idle in RUN: all enables=1, all clears=0, out_halted=0.
- States: RUN, STALL, DRAIN, HALT. Control outputs are combinational from state and inputs; counters and state are registered.
- Load-use hazard: lu = in_ex_memread & in_ex_rd!=0 & ((use_rs & rs==ex_rd) | (use_rt & rt==ex_rd)).
- Event priority within RUN: halt > branch > load-use > jump.
- RUN, halt (in_ex_halt=1):
  - pc_en=0, ifid_en=0, idex_clr=1, exmem_en=1, memwb_en=1.
  - Next state DRAIN with drain count=DRAIN_CYCLES.
- RUN, branch taken:
  - pc_en=1, ifid_clr=1, idex_clr=1; flushes+1.
  - Any concurrent lu or jump is ignored (wrong path).
- RUN, lu:
  - pc_en=0, ifid_en=0, idex_clr=1; stalls+1.
  - If LOAD_BUBBLES>1: next state STALL with bubble count=LOAD_BUBBLES-1. Otherwise remain in RUN.
  - Any concurrent jump is deferred; the jump is retried when ID re-evaluates.
- RUN, jump (no higher-priority event): ifid_clr=1, all other enables=1; flushes+1.
- STALL:
  - Outputs identical to the RUN lu case; stalls+1; bubble count decrements.
  - Return to RUN when count reaches 1.
  - Branch taken in STALL: handled as the RUN branch case and next state RUN immediately.
  - Halt in STALL: handled as the RUN halt case.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_en=0, exmem_en=1, memwb_en=1.
  - Count decrements; go to HALT when count reaches 1.
  - Branch, lu and jump are ignored.
- HALT:
  - All enables=0, clears=0, out_halted=1.
  - in_resume=1 sampled at a clock edge -> RUN on that edge.
  - in_resume held high in RUN has no effect.
- out_cycles increments in every state except HALT.
- All counters wrap modulo 2^32, with no saturation.
- Reset mid-STALL or mid-DRAIN returns to RUN immediately (asynchronous) and zeroes all counters.

Decomposition:
- Shared package: state encoding (RUN=2'd0, STALL=2'd1, DRAIN=2'd2, HALT=2'd3), register-zero constant 5'd0, and the counter width of 32.
- Natural sub-module: load_use_detect, combinational lu compare. It is reused by a future forwarding unit.
- The FSM and the counters stay in the top module.

Test Plan:
- Reset, then hold all inputs 0 for 10 cycles -> all enables=1, clears=0, out_cycles=10, stalls=0, flushes=0.
- ex_memread=1, ex_rd=5, id_rs=5, use_rs=1 for one cycle, LOAD_BUBBLES=1 -> that cycle pc_en=0, ifid_en=0, idex_clr=1; next cycle normal; stalls=1.
- Same stimulus with LOAD_BUBBLES=3 and ex_memread dropped after 1 cycle -> 3 consecutive bubble cycles, stalls=3. Repeat with ex_rd=0 -> no stall.
- lu and ex_branch_taken asserted together -> pc_en=1, ifid_clr=1, idex_clr=1, stalls unchanged, flushes=1. Branch taken during STALL cycle 2 -> RUN on next edge.
- ex_halt pulse with DRAIN_CYCLES=2 -> 1 halt cycle, then 2 DRAIN cycles with exmem_en=memwb_en=1, then HALT with all enables 0 and out_halted=1; out_cycles frozen for 5 cycles; resume -> RUN and counting continues.
- in_CLR asserted mid-DRAIN between clock edges -> state RUN and counters 0 immediately, without waiting for a clock edge.
